// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
package mul_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/twos_negate.sv
// Combinational conditional two's-complement negate.
module twos_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier: one multiplier bit per clock, sign handled
// by magnitude capture up front and a conditional negate on the final cycle.
module shift_add_mul
  import mul_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       is_signed,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       busy,
  output logic                       done,
  output logic [prod_w(WIDTH)-1:0]   result
);

  localparam int                 CNT_W = cnt_w(WIDTH);
  localparam int                 PW    = prod_w(WIDTH);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplr;
  logic [PW-1:0]      acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg;

  logic               sgn;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [PW-1:0]      acc_nxt;
  logic [PW-1:0]      prod;

  assign sgn = SIGNED_EN ? is_signed : 1'b0;

  // |-2^(WIDTH-1)| negates to itself, which reads correctly as unsigned.
  twos_negate #(.W(WIDTH)) u_neg_a (.neg(sgn & a[WIDTH-1]), .x(a), .y(a_mag));
  twos_negate #(.W(WIDTH)) u_neg_b (.neg(sgn & b[WIDTH-1]), .x(b), .y(b_mag));

  assign sum     = {1'b0, acc[PW-1:WIDTH]} + {1'b0, (mplr[0] ? mcand : '0)};
  assign acc_nxt = PW'({sum, acc[WIDTH-1:0]} >> 1);

  twos_negate #(.W(PW)) u_neg_p (.neg(neg), .x(acc_nxt), .y(prod));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      mcand  <= '0;
      mplr   <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            mcand <= a_mag;
            mplr  <= b_mag;
            neg   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc  <= acc_nxt;
          mplr <= mplr >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            result <= prod;
            done   <= 1'b1;
            busy   <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
